// File: rtl/joypad_serializer.sv
// NES controller-port serializer: 1, 2 or 4 players with Four Score multitap.
// Per-button autofire gating is applied ahead of the parallel load.
module joypad_serializer #(
  parameter int C_players      = 2,
  parameter int C_autofire_div = 1071428
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [C_players*8-1:0] i_buttons,
  input  logic [C_players*8-1:0] i_autofire_mask,
  input  logic                   i_strobe,
  input  logic [1:0]             i_joy_clock,
  output logic [1:0]             o_data,
  output logic                   o_latch_pulse
);

  localparam int NB = C_players * 8;
  localparam int CW = $clog2(C_autofire_div);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_autofire_div - 1);
  localparam logic [1:0] PORT_EN =
    (C_players == 1) ? 2'b01 : 2'b11;

  logic [NB-1:0]      R_btn;
  logic [NB-1:0]      R_mask;
  logic [1:0]         R_clk;
  logic               R_strobe;
  logic [CW-1:0]      cnt;
  logic               phase;
  logic [1:0][23:0]   sr;
  logic [1:0][4:0]    rc;
  logic [NB-1:0]      eff;
  logic [1:0][23:0]   img;
  logic [1:0]         fall;

  assign eff  = R_btn & (~R_mask | {NB{phase}});
  assign fall = R_clk & ~i_joy_clock & PORT_EN;

  // Four Score: P1/P2 first, then P3/P4, then signature byte.
  if (C_players == 4) begin : g_four
    assign img[0] = {8'h08, eff[23:16], eff[7:0]};
    assign img[1] = {8'h04, eff[31:24], eff[15:8]};
  end else if (C_players == 2) begin : g_two
    assign img[0] = {16'hFFFF, eff[7:0]};
    assign img[1] = {16'hFFFF, eff[15:8]};
  end else begin : g_one
    assign img[0] = {16'hFFFF, eff[7:0]};
    assign img[1] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R_btn         <= '0;
      R_mask        <= '0;
      R_clk         <= '0;
      R_strobe      <= 1'b0;
      cnt           <= '0;
      phase         <= 1'b0;
      sr            <= '0;
      rc            <= '0;
      o_latch_pulse <= 1'b0;
    end else begin
      R_btn         <= i_buttons;
      R_mask        <= i_autofire_mask;
      R_clk         <= i_joy_clock;
      R_strobe      <= i_strobe;
      o_latch_pulse <= R_strobe & ~i_strobe;
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (i_strobe) begin
          sr[p] <= img[p];
          rc[p] <= '0;
        end else if (fall[p]) begin
          sr[p] <= {1'b1, sr[p][23:1]};
          if (rc[p] != 5'd24)
            rc[p] <= rc[p] + 5'd1;
        end
      end
    end
  end

  assign o_data = {sr[1][0], sr[0][0]};

endmodule

// File: tb/tb_joypad_serializer.sv
// Bench for joypad_serializer: 1-, 2- and 4-player instances share strobe/clocks.
// Table vectors, random reads vs. a bit-index reference model, corner sequences.
module tb_joypad_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [1:0]  jclk;
  logic [15:0] btn2, msk2;
  logic [31:0] btn4, msk4;
  logic [7:0]  btn1, msk1;
  logic [1:0]  d2, d4, d1;
  logic        lp2, lp4, lp1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] c2_0, c2_1, c4_0, c4_1, c1_0, c1_1;

  always #5 clk = ~clk;

  joypad_serializer #(.C_players(2), .C_autofire_div(4)) u2 (
    .clk(clk), .reset(rst), .i_buttons(btn2),
    .i_autofire_mask(msk2), .i_strobe(strobe),
    .i_joy_clock(jclk), .o_data(d2), .o_latch_pulse(lp2));

  joypad_serializer #(.C_players(4), .C_autofire_div(4)) u4 (
    .clk(clk), .reset(rst), .i_buttons(btn4),
    .i_autofire_mask(msk4), .i_strobe(strobe),
    .i_joy_clock(jclk), .o_data(d4), .o_latch_pulse(lp4));

  joypad_serializer #(.C_players(1), .C_autofire_div(4)) u1 (
    .clk(clk), .reset(rst), .i_buttons(btn1),
    .i_autofire_mask(msk1), .i_strobe(strobe),
    .i_joy_clock(jclk), .o_data(d1), .o_latch_pulse(lp1));

  typedef struct {
    logic [15:0] btn;
    logic [9:0]  exp0;
    logic [9:0]  exp1;
  } vec_t;

  vec_t tbl[4];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Bit idx of the serial stream a standard pad / Four Score would emit.
  function automatic logic exp_bit(input int players, input int port,
                                   input logic [31:0] b, input int idx);
    logic [7:0] sig;
    if (players == 1 && port == 1) return 1'b0;
    if (players == 4) begin
      sig = (port == 0) ? 8'h08 : 8'h04;
      if (idx < 8)  return b[8*port + idx];
      if (idx < 16) return b[8*(port+2) + idx - 8];
      if (idx < 24) return sig[idx-16];
      return 1'b1;
    end
    if (idx < 8) return b[8*port + idx];
    return 1'b1;
  endfunction

  function automatic logic [25:0] exp_vec(input int players, input int port,
                                          input logic [31:0] b);
    logic [25:0] v;
    v = '0;
    for (int i = 0; i < 26; i++) v[i] = exp_bit(players, port, b, i);
    return v;
  endfunction

  task automatic read_seq();
    strobe = 1'b1;
    jclk   = 2'b00;
    cyc(); cyc();
    strobe = 1'b0;
    cyc();
    for (int k = 0; k < 26; k++) begin
      c2_0[k] = d2[0]; c2_1[k] = d2[1];
      c4_0[k] = d4[0]; c4_1[k] = d4[1];
      c1_0[k] = d1[0]; c1_1[k] = d1[1];
      jclk = 2'b11; cyc(); cyc();
      jclk = 2'b00; cyc(); cyc();
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " p2 port0"}, 32'(c2_0), 32'(exp_vec(2, 0, {16'h0, btn2})));
    check({tag, " p2 port1"}, 32'(c2_1), 32'(exp_vec(2, 1, {16'h0, btn2})));
    check({tag, " p4 port0"}, 32'(c4_0), 32'(exp_vec(4, 0, btn4)));
    check({tag, " p4 port1"}, 32'(c4_1), 32'(exp_vec(4, 1, btn4)));
    check({tag, " p1 port0"}, 32'(c1_0), 32'(exp_vec(1, 0, {24'h0, btn1})));
    check({tag, " p1 port1"}, 32'(c1_1), 32'(exp_vec(1, 1, {24'h0, btn1})));
  endtask

  logic s [17];
  int   bad, trans, ones;

  initial begin
    tbl[0] = '{16'h8101, 10'h301, 10'h381};
    tbl[1] = '{16'h0000, 10'h300, 10'h300};
    tbl[2] = '{16'hFF55, 10'h355, 10'h3FF};
    tbl[3] = '{16'h3C80, 10'h380, 10'h33C};

    rst = 1'b1; strobe = 1'b0; jclk = 2'b00;
    btn2 = '0; msk2 = '0; btn4 = '0; msk4 = '0; btn1 = '0; msk1 = '0;
    cyc(); cyc();
    check("reset d2", 32'(d2), 32'h0);
    check("reset d4", 32'(d4), 32'h0);
    check("reset d1", 32'(d1), 32'h0);
    check("reset latch", 32'({lp2, lp4, lp1}), 32'h0);
    rst = 1'b0;
    cyc();

    // Table: 2-player streams incl. 1-fill after bit 8
    for (int i = 0; i < 4; i++) begin
      btn2 = tbl[i].btn;
      btn4 = $urandom; btn1 = 8'($urandom);
      read_seq();
      check($sformatf("tbl%0d port0", i), 32'(c2_0[9:0]), 32'(tbl[i].exp0));
      check($sformatf("tbl%0d port1", i), 32'(c2_1[9:0]), 32'(tbl[i].exp1));
      check_model($sformatf("tbl%0d", i));
    end

    // Four Score stream
    btn2 = 16'h0201; btn4 = 32'h0080_0201; btn1 = 8'h01;
    read_seq();
    check("fourscore port0", 32'(c4_0), 32'h3088001);
    check("fourscore port1", 32'(c4_1), 32'h3040002);

    // Random reads against the model
    for (int r = 0; r < 8; r++) begin
      btn2 = 16'($urandom); btn4 = $urandom; btn1 = 8'($urandom);
      read_seq();
      check_model($sformatf("rand%0d", r));
    end

    // Strobe/clock collision
    btn2 = 16'h0101;
    strobe = 1'b1;
    cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      jclk = 2'b11; cyc(); cyc();
      jclk = 2'b00; cyc();
      check($sformatf("collide%0d data", k), 32'(d2[0]), 32'h1);
      check($sformatf("collide%0d lp", k), 32'(lp2), 32'h0);
      cyc();
      check($sformatf("collide%0d data b", k), 32'(d2[0]), 32'h1);
    end
    strobe = 1'b0;
    cyc();
    check("latch pulse rise", 32'(lp2), 32'h1);
    check("latch data A", 32'(d2[0]), 32'h1);
    cyc();
    check("latch pulse fall", 32'(lp2), 32'h0);
    jclk = 2'b11; cyc(); cyc();
    jclk = 2'b00; cyc();
    check("after collide bit1", 32'(d2[0]), 32'h0);

    // Autofire: masked A toggles 4 high / 4 low
    btn2 = 16'h0001; msk2 = 16'h0001;
    strobe = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    for (int k = 0; k < 17; k++) begin
      s[k] = d2[0];
      check("p1 port1 idle", 32'(d1[1]), 32'h0);
      cyc();
    end
    bad = 0; trans = 0; ones = 0;
    for (int k = 0; k < 13; k++) if (s[k+4] == s[k]) bad++;
    for (int k = 0; k < 16; k++) if (s[k+1] != s[k]) trans++;
    for (int k = 0; k < 8; k++) if (s[k]) ones++;
    check("autofire half-period", 32'(bad), 32'h0);
    check("autofire transitions", 32'(trans), 32'h4);
    check("autofire duty", 32'(ones), 32'h4);
    msk2 = 16'h0000;
    for (int k = 0; k < 4; k++) cyc();
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (d2[0]) ones++;
      cyc();
    end
    check("autofire off const", 32'(ones), 32'd16);
    strobe = 1'b0;
    cyc();

    // Asynchronous reset mid-read
    btn2 = 16'h0808; btn4 = 32'h0000_0808; btn1 = 8'h08;
    strobe = 1'b1; cyc(); cyc();
    strobe = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin
      jclk = 2'b11; cyc(); cyc();
      jclk = 2'b00; cyc(); cyc();
    end
    check("pre-reset d2", 32'(d2), 32'h3);
    check("pre-reset d4", 32'(d4), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check("async reset d2", 32'(d2), 32'h0);
    check("async reset d4", 32'(d4), 32'h0);
    check("async reset d1", 32'(d1), 32'h0);
    cyc();
    rst = 1'b0;
    btn2 = 16'h0101; btn4 = 32'h0302_0101; btn1 = 8'h01;
    cyc();
    read_seq();
    check_model("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
